// File: rtl/fifo_writer.sv
// fifo_writer: write-side master for the external byte FIFO in the display
// command path. Bytes come in on a valid/ready port and wait in a small
// circular queue. Each byte is then written with a timed, active-low nW pulse.
// A new write starts only while the synchronized full flag shows room.
// Optional build macro FIFO_WRITER_STATS_EN adds the saturating counters
// bytes_written and stall_cycles.
module fifo_writer #(
    parameter int DEPTH     = 4,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [7:0]              fifo_data,
    output logic                    fifo_nw,
    input  logic                    fifo_nff_in,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  level
`ifdef FIFO_WRITER_STATS_EN
    ,
    output logic [15:0]             bytes_written,
    output logic [15:0]             stall_cycles
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
    localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
    localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_GAP
    } state_t;

    // Full-flag synchronizer (r_nff_p1 is the synchronized flag, 0 = full)
    logic             r_nff_p0;
    logic             r_nff_p1;

    // Byte queue
    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_push;
    logic             w_pop;

    // Write sequencer
    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_cnt;
    logic [3:0]       w_cnt_nxt;
    logic             r_nw;
    logic             w_nw_nxt;
    logic [7:0]       r_data;
    logic [7:0]       w_data_nxt;

    assign in_ready  = ~nrst & (r_level != LVL_W'(DEPTH));
    assign w_push    = in_valid & in_ready;
    assign level     = r_level;
    assign fifo_nw   = r_nw;
    assign fifo_data = r_data;
    assign busy      = (r_level != '0) | (r_state != ST_IDLE);

    // Two-flop synchronizer for the asynchronous full flag; reset reads as full
    always_ff @(posedge clk) begin
        if (nrst) begin
            r_nff_p0 <= 1'b0;
            r_nff_p1 <= 1'b0;
        end else begin
            r_nff_p0 <= fifo_nff_in;
            r_nff_p1 <= r_nff_p0;
        end
    end

    // Queue storage: data only, needs no reset because level gates every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Queue pointers and occupancy; simultaneous push and pop leave level unchanged
    always_ff @(posedge clk) begin
        if (nrst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: ;
            endcase
        end
    end

    // Sequencer state, counter and registered FIFO-side outputs
    always_ff @(posedge clk) begin
        if (nrst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_nw    <= 1'b1;
            r_data  <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_nw    <= w_nw_nxt;
            r_data  <= w_data_nxt;
        end
    end

    // Next-state logic: full flag is consulted only in IDLE, so a started write always finishes
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_nw_nxt    = r_nw;
        w_data_nxt  = r_data;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_nw_nxt = 1'b1;
                if ((r_level != '0) && r_nff_p1) begin
                    w_data_nxt  = r_mem[r_rd_ptr];
                    w_cnt_nxt   = SETUP_LD;
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (r_cnt == 4'd0) begin
                    w_nw_nxt    = 1'b0;
                    w_cnt_nxt   = PULSE_LD;
                    w_state_nxt = ST_STROBE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_STROBE: begin
                if (r_cnt == 4'd0) begin
                    w_nw_nxt    = 1'b1;
                    w_pop       = 1'b1;
                    w_cnt_nxt   = HOLD_LD;
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_HOLD: begin
                if (r_cnt == 4'd0) begin
                    w_cnt_nxt   = 4'd1;
                    w_state_nxt = ST_GAP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_GAP: begin
                // Two idle cycles let the synchronized flag catch up with the last write
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_nw_nxt    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef FIFO_WRITER_STATS_EN
    logic [15:0] r_bytes_written;
    logic [15:0] r_stall_cycles;
    logic        w_stall;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign w_stall       = (r_state == ST_IDLE) && (r_level != '0) && !r_nff_p1;
    assign bytes_written = r_bytes_written;
    assign stall_cycles  = r_stall_cycles;

    // Saturating counts of completed strobes and full-flag stalls in IDLE
    always_ff @(posedge clk) begin
        if (nrst) begin
            r_bytes_written <= '0;
            r_stall_cycles  <= '0;
        end else begin
            if (w_pop) begin
                r_bytes_written <= sat_inc16(r_bytes_written);
            end
            if (w_stall) begin
                r_stall_cycles <= sat_inc16(r_stall_cycles);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_writer.sv
// Directed testbench for fifo_writer with default timing parameters.
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_fifo_writer;

    logic       clk = 1'b0;
    logic       nrst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] fifo_data;
    logic       fifo_nw;
    logic       fifo_nff_in;
    logic       busy;
    logic [2:0] level;
`ifdef FIFO_WRITER_STATS_EN
    logic [15:0] bytes_written;
    logic [15:0] stall_cycles;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fifo_writer #(
        .DEPTH(4), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .fifo_data(fifo_data),
        .fifo_nw(fifo_nw),
        .fifo_nff_in(fifo_nff_in),
        .busy(busy),
        .level(level)
`ifdef FIFO_WRITER_STATS_EN
        ,
        .bytes_written(bytes_written),
        .stall_cycles(stall_cycles)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input logic [7:0] d);
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Watchdog: the bench is fixed-length, this only guards against a stuck simulator
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int nfall;
        int nlow;
        int fall_t [6];
        logic [7:0] got [6];
        logic prev_nw;
        logic will_acc;
        bit full_checked;

        nrst        = 1'b1;
        in_data     = 8'h00;
        in_valid    = 1'b0;
        fifo_nff_in = 1'b1;
        @(negedge clk);
        ticks(3);

        // Reset state
        check("rst_nw", fifo_nw, 1);
        check("rst_data", fifo_data, 8'h00);
        check("rst_level", level, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", in_ready, 0);
        nrst = 1'b0;
        #1 check("rst_rel_ready", in_ready, 1);
        ticks(3);

        // Single byte, edge T is the push
        in_data = 8'h5A; in_valid = 1'b1;
        #1 check("t1_ready", in_ready, 1);
        tick(); in_valid = 1'b0;                 // after T
        check("t1_lvl_T", level, 1);
        check("t1_nw_T", fifo_nw, 1);
        tick();                                  // after T+1
        check("t1_data", fifo_data, 8'h5A);
        check("t1_nw_T1", fifo_nw, 1);
        tick();                                  // after T+2
        check("t1_nw_T2", fifo_nw, 0);
        tick();                                  // after T+3
        check("t1_nw_T3", fifo_nw, 0);
        check("t1_lvl_T3", level, 1);
        tick();                                  // after T+4
        check("t1_nw_T4", fifo_nw, 1);
        check("t1_lvl_T4", level, 0);
        check("t1_hold", fifo_data, 8'h5A);
        tick();
        check("t1_busy_T5", busy, 1);
        tick();
        check("t1_busy_T6", busy, 1);
        tick();
        check("t1_busy_T7", busy, 0);
        ticks(2);

        // Burst of six bytes back-to-back
        acc = 0; nfall = 0; nlow = 0; prev_nw = 1'b1; full_checked = 0;
        for (int i = 0; i < 6; i++) begin got[i] = 8'h00; fall_t[i] = 0; end
        for (int c = 0; c < 60; c++) begin
            if (!fifo_nw) nlow++;
            if (prev_nw && !fifo_nw) begin
                if (nfall < 6) begin got[nfall] = fifo_data; fall_t[nfall] = c; end
                nfall++;
            end
            prev_nw = fifo_nw;
            if (acc == 4 && !full_checked) begin
                check("burst_lvl4", level, 4);
                check("burst_notready", in_ready, 0);
                full_checked = 1;
            end
            in_valid = (acc < 6);
            in_data  = 8'(acc + 1);
            #1 will_acc = in_valid & in_ready;
            tick();
            if (will_acc) acc++;
        end
        in_valid = 1'b0;
        check("burst_acc", acc, 6);
        check("burst_pulses", nfall, 6);
        check("burst_lowcyc", nlow, 12);
        for (int i = 0; i < 6; i++) check($sformatf("burst_byte%0d", i), got[i], i + 1);
        for (int i = 0; i < 5; i++) check($sformatf("burst_gap%0d", i), fall_t[i+1] - fall_t[i], 7);
        check("burst_lvl_end", level, 0);

        // Full stall with three bytes queued
        fifo_nff_in = 1'b0;
        ticks(3);
        push(8'hA1); push(8'hA2); push(8'hA3);
        nlow = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (!fifo_nw) nlow++;
        end
        check("stall_nolow", nlow, 0);
        check("stall_lvl", level, 3);
        fifo_nff_in = 1'b1;
        ticks(3);
        check("stall_rel_P3", fifo_nw, 1);
        tick();
        check("stall_rel_P4", fifo_nw, 0);
        check("stall_rel_data", fifo_data, 8'hA1);
        ticks(25);
        check("stall_drain_lvl", level, 0);
        check("stall_drain_data", fifo_data, 8'hA3);
        check("stall_drain_busy", busy, 0);

        // Full flag falls during STROBE
        push(8'hB1); push(8'hB2);
        tick();
        check("nffs_strobe", fifo_nw, 0);
        fifo_nff_in = 1'b0;
        tick();
        check("nffs_still_low", fifo_nw, 0);
        tick();
        check("nffs_done", fifo_nw, 1);
        check("nffs_data", fifo_data, 8'hB1);
        check("nffs_lvl", level, 1);
        nlow = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (!fifo_nw) nlow++;
        end
        check("nffs_blocked", nlow, 0);
        check("nffs_blk_lvl", level, 1);
        fifo_nff_in = 1'b1;
        ticks(20);
        check("nffs_rel_lvl", level, 0);
        check("nffs_rel_data", fifo_data, 8'hB2);

        // Reset during STROBE with two bytes queued
        push(8'hC1); push(8'hC2);
        tick();
        check("mrst_pre_nw", fifo_nw, 0);
        check("mrst_pre_lvl", level, 2);
        nrst = 1'b1;
        tick();
        check("mrst_nw", fifo_nw, 1);
        check("mrst_lvl", level, 0);
        check("mrst_data", fifo_data, 8'h00);
        check("mrst_ready", in_ready, 0);
        check("mrst_busy", busy, 0);
        tick();
        check("mrst_ready2", in_ready, 0);
        nrst = 1'b0;
        #1 check("mrst_rel_ready", in_ready, 1);
        ticks(4);

`ifdef FIFO_WRITER_STATS_EN
        // Statistics: 10 stalled IDLE cycles, then 5 bytes written
        nrst = 1'b1;
        fifo_nff_in = 1'b0;
        ticks(2);
        check("stat_rst_bw", bytes_written, 0);
        check("stat_rst_sc", stall_cycles, 0);
        nrst = 1'b0;
        push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
        ticks(5);
        fifo_nff_in = 1'b1;
        ticks(40);
        push(8'hD5);
        ticks(15);
        check("stat_lvl", level, 0);
        check("stat_bw", bytes_written, 5);
        check("stat_sc", stall_cycles, 10);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
